// File: rtl/rename_pkg.sv
// Shared rename/issue constants and tag types.
package rename_pkg;
  localparam int AR_SIZE    = 7;
  localparam int AR_ARRAY   = 128;
  localparam int ARCH_SIZE  = 5;
  localparam int NUM_FU     = 3;
  localparam int NUM_ARCH   = 1 << ARCH_SIZE;
  localparam int FL_PRELOAD = AR_ARRAY - NUM_ARCH;

  typedef logic [AR_SIZE-1:0]   phys_tag_t;
  typedef logic [ARCH_SIZE-1:0] arch_idx_t;
  typedef logic [AR_SIZE:0]     count_t;
endpackage

// File: rtl/free_list_fifo.sv
// Circular free list of physical tags, preloaded with the tags not mapped at reset.
module free_list_fifo import rename_pkg::*; (
  input  logic      clk,
  input  logic      rst,
  input  logic      pop,
  input  logic      push,
  input  phys_tag_t push_tag,
  output phys_tag_t head_tag,
  output count_t    count,
  output logic      overflow_err
);
  phys_tag_t mem [AR_ARRAY];
  phys_tag_t head, tail;
  logic      full, push_ok, pop_ok;

  assign full     = count == count_t'(AR_ARRAY);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && count != '0;
  assign head_tag = mem[head];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < AR_ARRAY; i++)
        mem[i] <= (i < FL_PRELOAD) ? phys_tag_t'(i + NUM_ARCH) : '0;
      head         <= '0;
      tail         <= phys_tag_t'(FL_PRELOAD);
      count        <= count_t'(FL_PRELOAD);
      overflow_err <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[tail] <= push_tag;
        tail      <= tail + 1'b1;
      end
      if (pop_ok) head <= head + 1'b1;
      count <= count + count_t'(push_ok) - count_t'(pop_ok);
      // sticky: a push into a full list means the ROB freed a tag twice
      if (push && full) overflow_err <= 1'b1;
    end
  end
endmodule

// File: rtl/rename_unit.sv
// Single-issue register rename: RAT lookup/update, free-list allocation, ready vector.
module rename_unit import rename_pkg::*; (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  input  arch_idx_t           rs1_arch_in,
  input  arch_idx_t           rs2_arch_in,
  input  arch_idx_t           rd_arch_in,
  input  logic                rd_write_in,
  input  logic                stall_in,
  output logic                ready_out,
  output logic                valid_out,
  output phys_tag_t           rs1_out,
  output phys_tag_t           rs2_out,
  output phys_tag_t           rd_out,
  output phys_tag_t           old_rd_out,
  output logic [AR_ARRAY:0]   reg_ready_out,
  input  logic [NUM_FU-1:0]   wb_valid_in,
  input  phys_tag_t           wb_tag0_in,
  input  phys_tag_t           wb_tag1_in,
  input  phys_tag_t           wb_tag2_in,
  input  logic                retire_valid_in,
  input  phys_tag_t           retire_tag_in,
  output count_t              free_count_out,
  output logic                stall_out,
  output logic                overflow_err_out
);
  phys_tag_t             rat [NUM_ARCH];
  logic [AR_ARRAY-1:0]   reg_ready, ready_nxt;
  phys_tag_t             fl_head, new_rd, old_rd;
  phys_tag_t             wb_tag [NUM_FU];
  count_t                fl_count;
  logic                  need, alloc, retire_push;

  assign need        = rd_write_in && rd_arch_in != '0;
  assign ready_out   = valid_in && !stall_in && (!need || fl_count != '0);
  assign stall_out   = valid_in && !ready_out;
  assign alloc       = ready_out && need;
  assign new_rd      = alloc ? fl_head : '0;
  assign old_rd      = alloc ? rat[rd_arch_in] : '0;
  assign retire_push = retire_valid_in && retire_tag_in != '0;

  assign wb_tag[0] = wb_tag0_in;
  assign wb_tag[1] = wb_tag1_in;
  assign wb_tag[2] = wb_tag2_in;

  free_list_fifo u_fl (
    .clk          (clk),
    .rst          (rst),
    .pop          (alloc),
    .push         (retire_push),
    .push_tag     (retire_tag_in),
    .head_tag     (fl_head),
    .count        (fl_count),
    .overflow_err (overflow_err_out)
  );

  assign free_count_out = fl_count;
  assign reg_ready_out  = {1'b1, reg_ready};

  // x0 is never written since need excludes rd==0, so rat[0] stays 0
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_ARCH; i++) rat[i] <= phys_tag_t'(i);
    end else if (alloc) begin
      rat[rd_arch_in] <= fl_head;
    end
  end

  // allocation clear is applied last so it overrides a same-cycle writeback
  always_comb begin
    ready_nxt = reg_ready;
    for (int k = 0; k < NUM_FU; k++)
      if (wb_valid_in[k] && wb_tag[k] != '0) ready_nxt[wb_tag[k]] = 1'b1;
    if (alloc) ready_nxt[fl_head] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) reg_ready <= '1;
    else     reg_ready <= ready_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out  <= 1'b0;
      rs1_out    <= '0;
      rs2_out    <= '0;
      rd_out     <= '0;
      old_rd_out <= '0;
    end else if (!stall_in) begin
      valid_out  <= ready_out;
      rs1_out    <= rat[rs1_arch_in];
      rs2_out    <= rat[rs2_arch_in];
      rd_out     <= new_rd;
      old_rd_out <= old_rd;
    end
  end
endmodule
